// File: rtl/test_status_led_pkg.sv
// Shared definitions for the test status LED indicator: state encodings and timing helpers.
package test_status_led_pkg;

  // State encodings; fixture-level benches probe state_q with these values.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_PASS = 2'd2;
  localparam logic [1:0] ST_FAIL = 2'd3;

  // Cycles per blink half-period, floored and never below one.
  function automatic int unsigned blink_half(input int unsigned clk_freq,
                                             input int unsigned blink_hz);
    int unsigned half;
    if (blink_hz == 0) begin
      half = clk_freq;
    end else begin
      half = clk_freq / (2 * blink_hz);
    end
    if (half == 0) begin
      half = 1;
    end
    return half;
  endfunction

endpackage

// File: rtl/led_pwm_blink.sv
// Blink phase generator and free-running PWM dimmer for the status LED.
module led_pwm_blink
  import test_status_led_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 48_000_000,
  parameter int unsigned BLINK_HZ   = 2,
  parameter int unsigned PWM_BITS   = 8,
  parameter int unsigned BRIGHTNESS = 32
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_restart,
  output logic o_dim,
  output logic o_blink
);

  localparam int unsigned Half = blink_half(CLK_FREQ, BLINK_HZ);
  localparam int unsigned CntW = (Half > 1) ? $clog2(Half) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(Half - 1);

  logic [CntW-1:0]     blink_cnt_q, blink_cnt_d;
  logic                blink_ph_q, blink_ph_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;

  // Blink counter restarts "on" whenever the owner changes state, otherwise wraps and toggles.
  always_comb begin
    blink_cnt_d = blink_cnt_q;
    blink_ph_d  = blink_ph_q;
    if (i_restart) begin
      blink_cnt_d = '0;
      blink_ph_d  = 1'b1;
    end else if (blink_cnt_q == CntMax) begin
      blink_cnt_d = '0;
      blink_ph_d  = ~blink_ph_q;
    end else begin
      blink_cnt_d = blink_cnt_q + CntW'(1);
    end
    pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);
  end

  // Counter state; blink phase comes out of reset "on".
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      blink_cnt_q <= '0;
      blink_ph_q  <= 1'b1;
      pwm_cnt_q   <= '0;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      blink_ph_q  <= blink_ph_d;
      pwm_cnt_q   <= pwm_cnt_d;
    end
  end

  // BRIGHTNESS of zero keeps the LED dark permanently.
  assign o_dim   = (32'(pwm_cnt_q) < BRIGHTNESS);
  assign o_blink = blink_ph_q;

endmodule

// File: rtl/test_status_led.sv
// Turns a test fixture's running/passed flags into a latched result and RGB LED requests.
module test_status_led
  import test_status_led_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 48_000_000,
  parameter int unsigned BLINK_HZ   = 2,
  parameter int unsigned PWM_BITS   = 8,
  parameter int unsigned BRIGHTNESS = 32
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_running,
  input  logic i_passed,
  output logic o_red,
  output logic o_green,
  output logic o_blue,
  output logic o_done,
  output logic o_pass_latched
);

  logic       run_q;
  logic       rise, fall;
  logic [1:0] state_q, state_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic       red_q, red_d;
  logic       green_q, green_d;
  logic       blue_q, blue_d;
  logic       restart;
  logic       dim, blink;

  // run_q clears on reset, so a still-high i_running reads as a fresh rise afterwards.
  assign rise = i_running & ~run_q;
  assign fall = ~i_running & run_q;

  // Result FSM and latches; i_passed only matters on the falling edge of i_running.
  always_comb begin
    state_d = state_q;
    done_d  = done_q;
    pass_d  = pass_q;
    case (state_q)
      ST_IDLE: begin
        if (rise) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (fall) begin
          state_d = i_passed ? ST_PASS : ST_FAIL;
          done_d  = 1'b1;
          pass_d  = i_passed;
        end
      end
      default: begin
        if (rise) begin
          state_d = ST_RUN;
          done_d  = 1'b0;
          pass_d  = 1'b0;
        end
      end
    endcase
  end

  // Restart the blink on the same edge the new state lands so its first phase is "on".
  assign restart = (state_d != state_q);

  led_pwm_blink #(
    .CLK_FREQ  (CLK_FREQ),
    .BLINK_HZ  (BLINK_HZ),
    .PWM_BITS  (PWM_BITS),
    .BRIGHTNESS(BRIGHTNESS)
  ) u_pwm_blink (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_restart(restart),
    .o_dim    (dim),
    .o_blink  (blink)
  );

  // Colour map from the current state; only one colour can be selected at a time.
  always_comb begin
    red_d   = 1'b0;
    green_d = 1'b0;
    blue_d  = 1'b0;
    case (state_q)
      ST_RUN:  blue_d  = dim & blink;
      ST_PASS: green_d = dim;
      ST_FAIL: red_d   = dim & blink;
      default: ;
    endcase
  end

  // Edge detect, FSM, result latches and registered LED requests.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      run_q   <= 1'b0;
      state_q <= ST_IDLE;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      red_q   <= 1'b0;
      green_q <= 1'b0;
      blue_q  <= 1'b0;
    end else begin
      run_q   <= i_running;
      state_q <= state_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      red_q   <= red_d;
      green_q <= green_d;
      blue_q  <= blue_d;
    end
  end

  assign o_red          = red_q;
  assign o_green        = green_q;
  assign o_blue         = blue_q;
  assign o_done         = done_q;
  assign o_pass_latched = pass_q;

endmodule

// File: tb/tb_test_status_led.sv
// Directed bench: per-cycle vector table plus a hand-written asynchronous reset sequence.
// A second instance built with BRIGHTNESS=0 shares the stimulus and must stay dark.
module tb_test_status_led;
  import test_status_led_pkg::*;

  logic clk = 1'b0;
  logic rst, running, passed;
  logic r, g, b, done, pl;
  logic dr, dg, db, dd, dp;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  test_status_led #(
    .CLK_FREQ(16), .BLINK_HZ(2), .PWM_BITS(2), .BRIGHTNESS(3)
  ) u_dut (
    .i_clk(clk), .i_rst(rst), .i_running(running), .i_passed(passed),
    .o_red(r), .o_green(g), .o_blue(b), .o_done(done), .o_pass_latched(pl)
  );

  test_status_led #(
    .CLK_FREQ(16), .BLINK_HZ(2), .PWM_BITS(2), .BRIGHTNESS(0)
  ) u_dark (
    .i_clk(clk), .i_rst(rst), .i_running(running), .i_passed(passed),
    .o_red(dr), .o_green(dg), .o_blue(db), .o_done(dd), .o_pass_latched(dp)
  );

  typedef struct {
    logic       run;
    logic       pass;
    logic [4:0] exp;  // {red, green, blue, done, pass_latched}
    logic [1:0] st;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int n, input logic rn, input logic ps, input logic er,
                     input logic eg, input logic eb, input logic ed, input logic ep,
                     input logic [1:0] st);
    vec_t v;
    v.run  = rn;
    v.pass = ps;
    v.exp  = {er, eg, eb, ed, ep};
    v.st   = st;
    for (int k = 0; k < n; k++) vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    // Edge n counts posedges after reset release; PWM is dark when n % 4 == 0.
    add(20, 0, 0, 0, 0, 0, 0, 0, ST_IDLE);  // 1-20 idle
    add(1,  1, 0, 0, 0, 0, 0, 0, ST_RUN);   // 21 rise
    add(2,  1, 0, 0, 0, 1, 0, 0, ST_RUN);   // 22-23
    add(1,  1, 0, 0, 0, 0, 0, 0, ST_RUN);   // 24 pwm off
    add(1,  1, 0, 0, 0, 1, 0, 0, ST_RUN);   // 25
    add(4,  1, 0, 0, 0, 0, 0, 0, ST_RUN);   // 26-29 blink off
    add(2,  1, 0, 0, 0, 1, 0, 0, ST_RUN);   // 30-31
    add(1,  1, 0, 0, 0, 0, 0, 0, ST_RUN);   // 32
    add(1,  1, 0, 0, 0, 1, 0, 0, ST_RUN);   // 33
    add(4,  1, 0, 0, 0, 0, 0, 0, ST_RUN);   // 34-37
    add(2,  1, 0, 0, 0, 1, 0, 0, ST_RUN);   // 38-39
    add(1,  1, 0, 0, 0, 0, 0, 0, ST_RUN);   // 40
    add(1,  0, 1, 0, 0, 1, 1, 1, ST_PASS);  // 41 fall, passed
    add(2,  0, 0, 0, 1, 0, 1, 1, ST_PASS);  // 42-43 green, i_passed now low
    add(1,  0, 0, 0, 0, 0, 1, 1, ST_PASS);  // 44
    add(3,  0, 0, 0, 1, 0, 1, 1, ST_PASS);  // 45-47
    add(1,  0, 0, 0, 0, 0, 1, 1, ST_PASS);  // 48
    add(2,  0, 0, 0, 1, 0, 1, 1, ST_PASS);  // 49-50
    add(1,  1, 0, 0, 1, 0, 0, 0, ST_RUN);   // 51 new run clears result
    add(1,  1, 1, 0, 0, 0, 0, 0, ST_RUN);   // 52 i_passed high mid-run is ignored
    add(3,  1, 1, 0, 0, 1, 0, 0, ST_RUN);   // 53-55
    add(1,  1, 0, 0, 0, 0, 0, 0, ST_RUN);   // 56
    add(1,  0, 0, 0, 0, 0, 1, 0, ST_FAIL);  // 57 fall, failed
    add(2,  0, 0, 1, 0, 0, 1, 0, ST_FAIL);  // 58-59 red on
    add(1,  0, 0, 0, 0, 0, 1, 0, ST_FAIL);  // 60
    add(1,  0, 0, 1, 0, 0, 1, 0, ST_FAIL);  // 61
    add(4,  0, 1, 0, 0, 0, 1, 0, ST_FAIL);  // 62-65 blink off, i_passed ignored
    add(2,  0, 0, 1, 0, 0, 1, 0, ST_FAIL);  // 66-67
    add(1,  0, 0, 0, 0, 0, 1, 0, ST_FAIL);  // 68
    add(1,  0, 0, 1, 0, 0, 1, 0, ST_FAIL);  // 69
    add(1,  0, 0, 0, 0, 0, 1, 0, ST_FAIL);  // 70

    rst     = 1'b1;
    running = 1'b0;
    passed  = 1'b0;
    #1;
    chk("reset_outputs", {3'b0, r, g, b, done, pl}, 8'h00);
    chk("reset_state", {6'b0, u_dut.state_q}, {6'b0, ST_IDLE});
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      running = vecs[i].run;
      passed  = vecs[i].pass;
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("vec%0d_out", i + 1), {3'b0, r, g, b, done, pl}, {3'b0, vecs[i].exp});
      chk($sformatf("vec%0d_state", i + 1), {6'b0, u_dut.state_q}, {6'b0, vecs[i].st});
      chk($sformatf("vec%0d_dark", i + 1), {3'b0, dr, dg, db, dd, dp},
          {6'b0, vecs[i].exp[1:0]});
    end

    // Reset asserted between edges in the middle of a run, i_running held high.
    running = 1'b1;
    passed  = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rerun_state", {6'b0, u_dut.state_q}, {6'b0, ST_RUN});
    chk("rerun_done", {6'b0, done, pl}, 8'h00);
    repeat (3) @(posedge clk);
    #2;
    chk("pre_reset_blue", {5'b0, r, g, b}, 8'h01);
    rst = 1'b1;
    #1;
    chk("async_reset_out", {3'b0, r, g, b, done, pl}, 8'h00);
    chk("async_reset_state", {6'b0, u_dut.state_q}, {6'b0, ST_IDLE});
    chk("async_reset_dark", {3'b0, dr, dg, db, dd, dp}, 8'h00);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_release_state", {6'b0, u_dut.state_q}, {6'b0, ST_RUN});
    chk("post_release_out", {3'b0, r, g, b, done, pl}, 8'h00);
    @(posedge clk);
    #1;
    chk("post_release_blue", {3'b0, r, g, b, done, pl}, 8'h04);
    chk("post_release_dark", {5'b0, dr, dg, db}, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
